boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 19 +
 rtl/rx_edge_sync.sv | 28 ++
 rtl/boot_loader.sv | 193 +++++++++++++++++++
 tb/tb_boot_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared states and constants for the UART boot loader
package boot_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [7:0]  SYNC_BYTE              = 8'hA5;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 5_000_000;

endpackage

// File: rtl/rx_edge_sync.sv
// rtl/rx_edge_sync.sv - two-flop synchronizer and rising-edge detector for the UART flag
module rx_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resynchronize the flag and keep a delayed copy to find its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - UART frame receiver that loads words into memory while holding the CPU
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned           WORD_SIZE      = 16,
    parameter logic [WORD_SIZE-1:0]  BASE_ADDR      = '0,
    parameter int unsigned           TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_flag,
    output logic                 cpu_hold,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_we,
    output logic                 load_done,
    output logic                 load_err
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e               state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          index_q, index_d;
    logic [7:0]           hi_q, hi_d;
    logic [7:0]           csum_q, csum_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [7:0]           pend_data_q, pend_data_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 cpu_hold_q, cpu_hold_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;

    logic                 rx_evt;
    logic                 use_pend;
    logic                 byte_v;
    logic [7:0]           byte_val;
    logic                 gap_counting;
    logic [GAP_W-1:0]     gap_inc;
    logic                 timeout;

    rx_edge_sync u_rx_edge_sync (
        .clk     (clk),
        .rst_n   (reset),
        .async_i (rx_flag),
        .rise_o  (rx_evt)
    );

    // WRITE cannot consume a byte, so a byte landing there waits one cycle
    // in the pending register and is replayed ahead of any new arrival.
    assign use_pend     = pend_valid_q && (state_q != ST_WRITE);
    assign byte_v       = use_pend || (rx_evt && (state_q != ST_WRITE));
    assign byte_val     = use_pend ? pend_data_q : rx_data;

    assign gap_counting = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign gap_inc      = gap_q + GAP_W'(1);
    assign timeout      = gap_counting && !rx_evt && (gap_inc == GAP_W'(TIMEOUT_CYCLES));

    // Next-state, frame parsing, checksum, byte-gap watchdog and write port.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        index_d      = index_q;
        hi_d         = hi_q;
        csum_d       = csum_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        gap_d        = gap_q;
        cpu_hold_d   = cpu_hold_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (rx_evt && ((state_q == ST_WRITE) || use_pend)) begin
            pend_valid_d = 1'b1;
            pend_data_d  = rx_data;
        end else if (use_pend) begin
            pend_valid_d = 1'b0;
        end

        if (rx_evt) begin
            gap_d = '0;
        end else if (gap_counting) begin
            gap_d = gap_inc;
        end

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (byte_v && (byte_val == SYNC_BYTE)) begin
                    state_d    = ST_LEN_HI;
                    csum_d     = 8'h00;
                    cpu_hold_d = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (byte_v) begin
                    len_d[15:8] = byte_val;
                    csum_d      = csum_q ^ byte_val;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (byte_v) begin
                    len_d[7:0] = byte_val;
                    csum_d     = csum_q ^ byte_val;
                    if ({len_q[15:8], byte_val} == 16'h0000) begin
                        state_d = ST_CHECK;
                    end else begin
                        index_d = 16'h0000;
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (byte_v) begin
                    hi_d    = byte_val;
                    csum_d  = csum_q ^ byte_val;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (byte_v) begin
                    csum_d      = csum_q ^ byte_val;
                    mem_addr_d  = BASE_ADDR + WORD_SIZE'(index_q);
                    mem_wdata_d = WORD_SIZE'({hi_q, byte_val});
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                index_d = index_q + 16'd1;
                if ((index_q + 16'd1) == len_q) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (byte_v) begin
                    state_d = (byte_val == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                cpu_hold_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout) begin
            state_d    = ST_ERROR;
            cpu_hold_d = 1'b1;
        end
    end

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= 16'h0000;
            index_q      <= 16'h0000;
            hi_q         <= 8'h00;
            csum_q       <= 8'h00;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            gap_q        <= '0;
            cpu_hold_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            index_q      <= index_d;
            hi_q         <= hi_d;
            csum_q       <= csum_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            gap_q        <= gap_d;
            cpu_hold_q   <= cpu_hold_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign cpu_hold  = cpu_hold_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = (state_q == ST_WRITE);
    assign load_done = (state_q == ST_DONE);
    assign load_err  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader with a frame-level model
module tb_boot_loader;

    localparam int          TMO  = 100;
    localparam logic [15:0] BASE = 16'h0000;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        rx_flag = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cpu_hold, mem_we, load_done, load_err;
    logic [15:0] mem_addr, mem_wdata;

    boot_loader #(
        .WORD_SIZE      (16),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_flag   (rx_flag),
        .cpu_hold  (cpu_hold),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         started  = 1'b0;
    wr_t        exp_wr[$];
    wr_t        cmp_w;
    int         exp_done = 0;
    logic       exp_hold = 1'b0;
    logic       exp_err  = 1'b0;
    logic [7:0] frame_q[$];
    logic [7:0] model_cs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: walk the first n_used bytes of frame_q as the receiver
    // would see them and derive the writes, done pulses and final hold/error levels.
    task automatic model_frame(input int n_used);
        int          p;
        int          pos;
        logic [15:0] n;
        logic [7:0]  cs;
        p = -1;
        for (int i = 0; i < n_used; i++) begin
            if (frame_q[i] == 8'hA5) begin
                p = i;
                break;
            end
        end
        if (p < 0) return;
        exp_hold = 1'b1;
        exp_err  = 1'b0;
        if (n_used < p + 3) return;
        n   = {frame_q[p+1], frame_q[p+2]};
        cs  = frame_q[p+1] ^ frame_q[p+2];
        pos = p + 3;
        for (int w = 0; w < int'(n); w++) begin
            if (pos + 1 >= n_used) return;
            exp_wr.push_back(wr_t'({16'(BASE + w), frame_q[pos], frame_q[pos+1]}));
            cs  = cs ^ frame_q[pos] ^ frame_q[pos+1];
            pos = pos + 2;
        end
        model_cs = cs;
        if (pos >= n_used) return;
        if (frame_q[pos] == cs) begin
            exp_done++;
            exp_hold = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_flag = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        rx_flag = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic send_frame(input int n_used, input int hi, input int lo);
        for (int i = 0; i < n_used; i++) begin
            send_byte(frame_q[i], hi, lo);
            if (i == 0 && frame_q[0] == 8'hA5 && hi >= 3) begin
                #1;
                check("hold_after_sync", cpu_hold, 1);
            end
        end
    endtask

    task automatic end_check(input string name);
        repeat (8) @(posedge clk);
        #1;
        check({name, "_writes_left"}, exp_wr.size(), 0);
        check({name, "_done_left"}, exp_done, 0);
        check({name, "_cpu_hold"}, cpu_hold, exp_hold);
        check({name, "_load_err"}, load_err, exp_err);
    endtask

    // Per-cycle comparison of the DUT against the model's expectations.
    always @(negedge clk) begin
        if (started) begin
            if (!reset) begin
                check("rst_ctrl", {cpu_hold, mem_we, load_done, load_err}, 0);
                check("rst_addr", mem_addr, 0);
                check("rst_wdata", mem_wdata, 0);
            end else begin
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
                    end else begin
                        cmp_w = exp_wr.pop_front();
                        check("wr_addr", mem_addr, cmp_w.a);
                        check("wr_data", mem_wdata, cmp_w.d);
                    end
                end
                if (load_done) begin
                    check("done_expected", exp_done > 0, 1);
                    if (exp_done > 0) exp_done--;
                end
                if (load_err) check("err_implies_hold", cpu_hold, 1);
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got no finish by 100000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        reset   = 1'b0;
        started = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_hold", cpu_hold, 0);
        check("reset_err", load_err, 0);

        // Stray bytes while idle are ignored.
        frame_q = {8'h11, 8'h22};
        model_frame(2);
        send_frame(2, 4, 3);
        end_check("idle_noise");

        // Two-word load; XOR of 00 02 12 34 AB CD is 0x42.
        frame_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        model_frame(8);
        check("pin_cs", model_cs, 8'h42);
        check("pin_wr0", exp_wr[0], 32'h0000_1234);
        check("pin_wr1", exp_wr[1], 32'h0001_ABCD);
        check("pin_done", exp_done, 1);
        send_frame(8, 4, 3);
        end_check("two_words");

        // Empty load.
        frame_q = {8'hA5, 8'h00, 8'h00, 8'h00};
        model_frame(4);
        check("pin_empty_wr", exp_wr.size(), 0);
        send_frame(4, 4, 3);
        end_check("empty");

        // Bad checksum then a good frame.
        frame_q = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
        model_frame(6);
        check("pin_bad_err", exp_err, 1);
        send_frame(6, 4, 3);
        end_check("bad_cs");
        frame_q = {8'hA5, 8'h00, 8'h01, 8'h55, 8'h66, 8'h32};
        model_frame(6);
        send_frame(6, 4, 3);
        end_check("recover");

        // Back-to-back bytes at the fastest flag rate.
        frame_q = {8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h04};
        model_frame(10);
        check("pin_fast_cs", model_cs, 8'h04);
        send_frame(10, 1, 1);
        end_check("fast");

        // Byte gap timeout after A5 00.
        frame_q = {8'hA5, 8'h00};
        model_frame(2);
        send_byte(8'hA5, 4, 3);
        @(posedge clk);
        #1;
        rx_data = 8'h00;
        rx_flag = 1'b1;
        for (int k = 1; k <= 104; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) rx_flag = 1'b0;
            if (k == 102) check("tmo_before", load_err, 0);
            if (k == 103) check("tmo_at", load_err, 1);
        end
        exp_err  = 1'b1;
        exp_hold = 1'b1;
        end_check("timeout");
        frame_q = {8'hA5, 8'h00, 8'h01, 8'h55, 8'h66, 8'h32};
        model_frame(6);
        send_frame(6, 4, 3);
        end_check("recover2");

        // Reset between data words.
        frame_q = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
        model_frame(5);
        send_frame(5, 4, 3);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_wdata", mem_wdata, 16'h1122);
        reset = 1'b0;
        #1;
        check("async_rst_hold", cpu_hold, 0);
        check("async_rst_addr", mem_addr, 0);
        check("async_rst_wdata", mem_wdata, 0);
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        exp_hold = 1'b0;
        exp_err  = 1'b0;
        for (int i = 5; i < 10; i++) send_byte(frame_q[i], 4, 3);
        end_check("mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
